relu_result_writeback: RTL

Downstream neighbour of dot_product_multiplication_unit. When that unit pulses done, this block captures its relu_out vector and active_units mask in one cycle. It then streams each active lane's word into the output activation buffer, one word per handshake, over a valid/ready write port. It frees the compute unit to start the next dot product while results drain.

---
 rtl/tpu_pkg.sv | 16 +
 rtl/lsb_priority_encoder.sv | 21 ++
 rtl/relu_result_writeback.sv | 94 +++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Types shared by the dot-product datapath and its result writeback stage.
package tpu_pkg;

    localparam int DEFAULT_WIDTH     = 16;
    localparam int DEFAULT_NUM_UNITS = 16;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;
    typedef word_t [DEFAULT_NUM_UNITS-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/lsb_priority_encoder.sv
// Combinational lowest-set-bit encoder: index of the least significant 1 in mask.
module lsb_priority_encoder #(
    parameter int N     = 16,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     mask,
    output logic [IDX_W-1:0] idx,
    output logic             any_set
);

    // Scan downward so the lowest set bit is the last one to overwrite idx.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) idx = IDX_W'(i);
        end
    end

    assign any_set = |mask;

endmodule

// File: rtl/relu_result_writeback.sv
// Captures a ReLU result vector on done_in and drains each active lane into the
// activation buffer over a valid/ready write port, lowest lane first.
//
// state | meaning
// IDLE  | waiting for done_in, capture registers idle
// WRITE | presenting lowest pending lane until buffer accepts it
// DONE  | single-cycle wb_done pulse, then back to IDLE
module relu_result_writeback
    import tpu_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int NUM_UNITS  = DEFAULT_NUM_UNITS,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             done_in,
    input  logic [NUM_UNITS-1:0]             active_units,
    input  logic [NUM_UNITS-1:0][WIDTH-1:0]  relu_in,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    output logic                             wr_valid,
    input  logic                             wr_ready,
    output logic [ADDR_WIDTH-1:0]            wr_addr,
    output logic [WIDTH-1:0]                 wr_data,
    output logic                             busy,
    output logic                             wb_done,
    output logic                             overrun
);

    localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    wb_state_t                       state;
    logic [NUM_UNITS-1:0]            pending;
    logic [NUM_UNITS-1:0]            pending_clr;
    logic [NUM_UNITS-1:0][WIDTH-1:0] cap_data;
    logic [ADDR_WIDTH-1:0]           cap_base;
    logic [IDX_W-1:0]                lane_idx;
    logic                            lane_any;
    logic                            handshake;

    lsb_priority_encoder #(
        .N     (NUM_UNITS),
        .IDX_W (IDX_W)
    ) u_lane_sel (
        .mask    (pending),
        .idx     (lane_idx),
        .any_set (lane_any)
    );

    // Address and data are pure functions of held registers, so they stay
    // stable for as long as the buffer stalls.
    assign wr_valid    = (state == WRITE) && lane_any;
    assign wr_addr     = wr_valid ? cap_base + ADDR_WIDTH'(lane_idx) : '0;
    assign wr_data     = wr_valid ? cap_data[lane_idx] : '0;
    assign busy        = (state != IDLE);
    assign wb_done     = (state == DONE);
    assign handshake   = wr_valid && wr_ready;
    assign pending_clr = pending & ~(NUM_UNITS'(1) << lane_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pending  <= '0;
            cap_data <= '0;
            cap_base <= '0;
            overrun  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (done_in) begin
                        cap_data <= relu_in;
                        cap_base <= base_addr;
                        pending  <= active_units;
                        state    <= (|active_units) ? WRITE : DONE;
                    end
                end
                WRITE: begin
                    if (done_in) overrun <= 1'b1;
                    if (handshake) begin
                        pending <= pending_clr;
                        if (pending_clr == '0) state <= DONE;
                    end
                end
                DONE: begin
                    // The compute unit may not refill until IDLE is reached.
                    if (done_in) overrun <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
